// File: rtl/borrow_lookahead_subtractor_seq.sv
`default_nettype none
// ============================================================================
// Module   : borrow_lookahead_subtractor_seq
// Purpose  : Multi-cycle a - b - b_in, one 4-bit borrow-lookahead slice per
//            clock, with valid/ready handshakes. Macro BLS_OVF_EN builds ovf.
// Revision : 1.0 - initial release
// ============================================================================
module borrow_lookahead_subtractor_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             ovf
);

  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             b_out_q, b_out_d;

  logic [CW+1:0]    slice_lo;
  logic [3:0]       sa, sb, g, p, d;
  logic [4:0]       br;
  logic             last_slice;

  assign slice_lo   = {cnt_q, 2'b00};
  assign sa         = a_q[slice_lo +: 4];
  assign sb         = b_q[slice_lo +: 4];
  assign last_slice = (cnt_q == CW'(N - 1));

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign g[i] = ~sa[i] & sb[i];
    assign p[i] = ~(sa[i] ^ sb[i]);
    assign d[i] = sa[i] ^ sb[i] ^ br[i];
  end

  // Flattened lookahead: every slice borrow depends only on g, p and br0.
  assign br[0] = br_q;
  assign br[1] = g[0] | (p[0] & br[0]);
  assign br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & br[0]);
  assign br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & br[0]);
  assign br[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & br[0]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    diff_d  = diff_q;
    b_out_d = b_out_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          br_d    = b_in;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        diff_d[slice_lo +: 4] = d;
        br_d                  = br[4];
        cnt_d                 = cnt_q + CW'(1);
        if (last_slice) begin
          b_out_d = br[4];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      b_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      b_out_q <= b_out_d;
    end
  end

`ifdef BLS_OVF_EN
  logic ovf_q, ovf_d;

  // Overflow uses the MSB of the slice being written, not the stale register.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == S_RUN && last_slice)
      ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (d[3] != a_q[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign diff      = diff_q;
  assign b_out     = b_out_q;

endmodule
`default_nettype wire

// File: tb/tb_borrow_lookahead_subtractor_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_borrow_lookahead_subtractor_seq
// Purpose  : Directed and random checks of the sequential borrow-lookahead
//            subtractor against an integer-arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_borrow_lookahead_subtractor_seq;
  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         b_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         b_out;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  borrow_lookahead_subtractor_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .b_out(b_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer subtraction, signed range test for overflow.
  task automatic ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rbin,
                           output logic [W-1:0] rd, output logic rbo, output logic rov);
    int ur, sr;
    ur  = int'(ra) - int'(rb) - int'(rbin);
    sr  = int'($signed(ra)) - int'($signed(rb)) - int'(rbin);
    rd  = W'(ur);
    rbo = (ur < 0);
`ifdef BLS_OVF_EN
    rov = (sr > 32767) || (sr < -32768);
`else
    rov = 1'b0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbin, input string tag);
    int k = 0;
    while (!in_ready && k < 50) begin tick(); k++; end
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; a = xa; b = xb; b_in = xbin;
    tick();
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); b_in = 1'($urandom);
  endtask

  task automatic expect_result(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbin, input string tag);
    logic [W-1:0] ed;
    logic         ebo, eov;
    int lat = 0;
    ref_model(xa, xb, xbin, ed, ebo, eov);
    while (!out_valid && lat < 50) begin tick(); lat++; end
    chk({tag, "_latency"}, 32'(lat), 32'(N));
    chk({tag, "_diff"},  32'(diff),  32'(ed));
    chk({tag, "_b_out"}, 32'(b_out), 32'(ebo));
    chk({tag, "_ovf"},   32'(ovf),   32'(eov));
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbin,
                       input int delay, input string tag);
    send(xa, xb, xbin, tag);
    expect_result(xa, xb, xbin, tag);
    repeat (delay) tick();
    release_out(tag);
  endtask

  initial begin
    logic [W-1:0] ra, rb, held;
    logic         rbin;
    logic         seen;

    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff",      32'(diff),      32'd0);
    chk("rst_b_out",     32'(b_out),     32'd0);
    chk("rst_ovf",       32'(ovf),       32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);

    // Directed operations
    do_op(16'h1234, 16'h0234, 1'b0, 0, "basic");
    chk("basic_const_diff", 32'(diff), 32'h1000);
    do_op(16'h0000, 16'h0001, 1'b0, 1, "underflow");
    do_op(16'h5555, 16'h5555, 1'b1, 0, "eq_bin");
    do_op(16'h8000, 16'h0001, 1'b0, 2, "sovf");
    do_op(16'h7FFF, 16'hFFFF, 1'b1, 0, "nosovf");

    // Backpressure: DONE held with a competing offer present
    send(16'h1111, 16'h0101, 1'b0, "hold");
    expect_result(16'h1111, 16'h0101, 1'b0, "hold");
    held = diff;
    in_valid = 1'b1; a = 16'h4321; b = 16'h1234; b_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("hold_diff_%0d", i),  32'(diff),      32'(held));
      chk($sformatf("hold_rdy_%0d", i),   32'(in_ready),  32'd0);
      chk($sformatf("hold_valid_%0d", i), 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hold_rel_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    expect_result(16'h4321, 16'h1234, 1'b1, "after_hold");
    release_out("after_hold");

    // Reset during slice 2 aborts the operation
    send(16'h1234, 16'h4321, 1'b0, "abort");
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_diff",  32'(diff),      32'd0);
    chk("abort_b_out", 32'(b_out),     32'd0);
    chk("abort_ovf",   32'(ovf),       32'd0);
    chk("abort_ready", 32'(in_ready),  32'd1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen = seen | out_valid;
    end
    chk("abort_never_valid", 32'(seen), 32'd0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 0, "post_abort");
    chk("post_abort_const", 32'(diff), 32'hFFFE);

    // Random operations
    for (int i = 0; i < 40; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom);
      if (i % 8 == 0) rb = ra;
      do_op(ra, rb, rbin, int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
